// File: rtl/matrix_if.sv
// Operand/result port bundle between the matrix engine and its RAM address controller.
interface matrix_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;

  modport master (output data_in, input ready, busy, done, data_out);
  modport slave  (input data_in, output ready, busy, done, data_out);
endinterface

// File: rtl/matrix.sv
// 3x3 matrix multiply C = A x B: loads 18 operand words, runs 27 sequential MACs,
// then presents 9 result words, then halts until clr.
module matrix #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     clr,
  matrix_if.slave bus
);

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    OUTPUT,
    HALT
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q;
  logic [1:0]       i_q, j_q, k_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q [18];
  logic [WIDTH-1:0] c_q    [9];
  logic [4:0]       a_idx, b_idx;
  logic [3:0]       c_idx;
  logic             last_mac;

  // A occupies operand slots 0..8 and B slots 9..17, both row-major.
  always_comb begin
    a_idx    = {3'b000, i_q} * 5'd3 + {3'b000, k_q};
    b_idx    = 5'd9 + {3'b000, k_q} * 5'd3 + {3'b000, j_q};
    c_idx    = {2'b00, i_q} * 4'd3 + {2'b00, j_q};
    acc_d    = acc_q + opnd_q[a_idx] * opnd_q[b_idx];
    last_mac = (i_q == 2'd2) && (j_q == 2'd2) && (k_q == 2'd2);
  end

  always_comb begin
    state_d      = state_q;
    bus.ready    = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.data_out = '0;
    case (state_q)
      LOAD: begin
        bus.ready = 1'b1;
        if (cnt_q == 5'd17) state_d = COMPUTE;
      end
      COMPUTE: begin
        bus.busy = 1'b1;
        if (last_mac) state_d = OUTPUT;
      end
      OUTPUT: begin
        bus.done     = 1'b1;
        bus.data_out = c_q[cnt_q[3:0]];
        if (cnt_q == 5'd8) state_d = HALT;
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
      acc_q <= '0;
      for (int unsigned n = 0; n < 18; n++) opnd_q[n] <= '0;
      for (int unsigned n = 0; n < 9; n++)  c_q[n]    <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          opnd_q[cnt_q] <= bus.data_in;
          cnt_q         <= (cnt_q == 5'd17) ? '0 : cnt_q + 5'd1;
        end
        COMPUTE: begin
          // k innermost, then j, then i; the k=2 step commits C[i][j] and restarts the sum.
          if (k_q == 2'd2) begin
            c_q[c_idx] <= acc_d;
            acc_q      <= '0;
            k_q        <= '0;
            if (j_q == 2'd2) begin
              j_q <= '0;
              i_q <= (i_q == 2'd2) ? '0 : i_q + 2'd1;
            end else begin
              j_q <= j_q + 2'd1;
            end
          end else begin
            acc_q <= acc_d;
            k_q   <= k_q + 2'd1;
          end
        end
        OUTPUT: cnt_q <= (cnt_q == 5'd8) ? '0 : cnt_q + 5'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix.sv
// Bench for the matrix engine: table of operand/result sets, a result queue, and clr-abort sequences.
module tb_matrix;

  typedef logic [8:0][31:0] mat_t;
  typedef struct packed {
    mat_t a;
    mat_t b;
    mat_t c;
  } vec_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] exp_q[$];
  vec_t tbl[6];

  matrix_if #(.WIDTH(32)) bus ();
  matrix #(.WIDTH(32)) dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  function automatic mat_t seq(input int start, input int step);
    mat_t m;
    for (int n = 0; n < 9; n++) m[n] = 32'(start + step * n);
    return m;
  endfunction

  function automatic mat_t fill(input logic [31:0] v);
    mat_t m;
    for (int n = 0; n < 9; n++) m[n] = v;
    return m;
  endfunction

  function automatic mat_t ident();
    mat_t m = '0;
    m[0] = 32'd1; m[4] = 32'd1; m[8] = 32'd1;
    return m;
  endfunction

  function automatic mat_t matmul(input mat_t a, input mat_t b);
    mat_t m;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        logic [31:0] s = '0;
        for (int k = 0; k < 3; k++) s = s + a[r*3+k] * b[k*3+c];
        m[r*3+c] = s;
      end
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Releases clr, feeds operands as the controller would, checks flags every cycle
  // and drains results from the queue; abort_cyc >= 0 reasserts clr in that cycle.
  task automatic run_seq(input vec_t v, input int abort_cyc);
    logic [2:0] exp_flags;
    for (int n = 0; n < 9; n++) exp_q.push_back(v.c[n]);
    @(posedge clk);
    #1 clr = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c < 9)       bus.data_in = v.a[c];
      else if (c < 18) bus.data_in = v.b[c-9];
      else             bus.data_in = $urandom;
      @(negedge clk);
      if (c == abort_cyc) begin
        clr = 1'b1;
        #1;
        check("abort_flags", {29'd0, bus.ready, bus.busy, bus.done}, 32'd4);
        check("abort_data_out", bus.data_out, 32'd0);
        exp_q.delete();
        return;
      end
      if (c < 18)      exp_flags = 3'b100;
      else if (c < 45) exp_flags = 3'b010;
      else if (c < 54) exp_flags = 3'b001;
      else             exp_flags = 3'b000;
      check($sformatf("flags_c%0d", c), {29'd0, bus.ready, bus.busy, bus.done}, {29'd0, exp_flags});
      if (bus.done) begin
        if (exp_q.size() > 0) check($sformatf("data_out_c%0d", c), bus.data_out, exp_q.pop_front());
        else check("queue_underflow", 32'd1, 32'd0);
      end else begin
        check($sformatf("idle_data_out_c%0d", c), bus.data_out, 32'd0);
      end
      @(posedge clk);
      #1;
    end
    check("results_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    clr = 1'b1;
  endtask

  initial begin
    mat_t ra, rb;
    bus.data_in = '0;
    tbl[0] = '{a: seq(1, 1), b: seq(9, -1),
               c: {32'd90, 32'd114, 32'd138, 32'd54, 32'd69, 32'd84, 32'd18, 32'd24, 32'd30}};
    tbl[1] = '{a: ident(), b: seq(1, 1), c: seq(1, 1)};
    tbl[2] = '{a: seq(1, 1), b: ident(), c: seq(1, 1)};
    tbl[3] = '{a: fill(32'hFFFFFFFF), b: fill(32'd2), c: fill(32'hFFFFFFFA)};
    tbl[4] = '{a: '0, b: '0, c: '0};
    tbl[4].a[0] = 32'h00010000;
    tbl[4].b[0] = 32'h00010000;
    for (int n = 0; n < 9; n++) begin
      ra[n] = $urandom;
      rb[n] = $urandom;
    end
    tbl[5] = '{a: ra, b: rb, c: matmul(ra, rb)};

    #1;
    check("reset_flags", {29'd0, bus.ready, bus.busy, bus.done}, 32'd4);
    check("reset_data_out", bus.data_out, 32'd0);

    for (int t = 0; t < 6; t++) run_seq(tbl[t], -1);

    run_seq(tbl[5], 30);
    run_seq(tbl[3], -1);
    run_seq(tbl[0], 50);
    run_seq(tbl[1], -1);
    run_seq(tbl[2], 5);
    run_seq(tbl[0], -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
